alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer: accepts one WIDTH-bit operation, then drives a single instance of the team's 1-bit ALU slice once per cycle, LSB to MSB.
- Between cycles it holds the carry, shifts the operands and assembles the result.
- Compare ops take one extra cycle in which the slice resolves less/equal.
- Sits between decode/issue and writeback as the low-area ALU alternative; ready/valid on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request valid
- in_ready  output  1  controller can accept; high only in IDLE
- ctrl  input  4  [3]=A_invert, [2]=B_invert, [1:0]=operation (0 AND, 1 OR, 2 ADD, 3 COMPARE)
- bonus_op  input  3  compare select: 0 lt, 1 gt, 2 le, 3 ge, 4 eq, 5 ne, 6/7 constant 0
- src1  input  WIDTH  operand A
- src2  input  WIDTH  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- cout  output  1  MSB carry out; ADD-class only, else 0
- overflow  output  1  signed overflow; ADD-class only, else 0

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, zero=1, cout=0, overflow=0. Carry, counter and operand registers are cleared.
- Reset mid-operation aborts the operation with no output. The next accepted op starts clean, with carry = its own B_invert.
- States:
  - IDLE: on in_valid && in_ready, latch ctrl, bonus_op, src1, src2; set carry = ctrl[2]; set bit_idx=0; go to RUN.
  - RUN: one slice evaluation per cycle on bit 0 of the operand shift registers.
    - Slice operation = ctrl[1:0], except COMPARE is driven as 2 (sum).
    - Shift the result in at the MSB: res <= {slice_result, res[WIDTH-1:1]}.
    - Shift the operands right; carry <= slice cout.
    - Accumulate diff_zero &= ~slice_result.
    - At bit_idx == WIDTH-1: capture MSB sum and slice overflow; go to DONE, or to RESOLVE if operation == 3.
  - RESOLVE (compare only): drive the slice with operation 3 and bonus_op.
    - less = msb_sum ^ msb_overflow; equal = diff_zero.
    - result = {(WIDTH-1) zeros, slice_result}; go to DONE.
  - DONE: out_valid=1, all outputs held stable. On out_ready go to IDLE.
- in_ready=0 outside IDLE. in_valid there is ignored; no queueing.
- Latency from the accepting edge to out_valid: WIDTH cycles for AND/OR/ADD-class ops, WIDTH+1 for COMPARE.
- Minimum issue interval is latency + 1, because DONE->IDLE is a separate cycle.
- cout and overflow come from the MSB slice for operation 2 only; 0 for AND/OR/COMPARE. zero is computed from the final result for all ops.
- Named encodings: NOR = 4'b1100, NAND = 4'b1101, SUB = 4'b0110 (carry-in 1 through B_invert), SLT-class = 4'b0111.
- Any 4-bit ctrl is legal and follows the bit meanings above.

Decomposition:
- Shared header alu_defs.vh: ctrl encodings (AND, OR, ADD, SUB, NOR, NAND, CMP), bonus_op encodings, FSM state constants.
- One sub-module: the existing 1-bit slice alu_bot, instantiated once. No other hierarchy.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0; out_valid exactly 32 cycles after accept.
- SUB 5 - 5 -> result 0, zero=1, cout=1, overflow=0. SUB 3 - 5 -> 0xFFFFFFFE, cout=0.
- CMP:
  - lt(0xFFFFFFFF, 1) -> 1.
  - gt(0x80000000, 1) -> 0, which checks overflow correction of less.
  - eq(7, 7) -> 1; ne(7, 7) -> 0; bonus_op 6 -> 0.
  - Each with 33-cycle latency and upper bits 0.
- NOR(0, 0) -> 0xFFFFFFFF; NAND(0xFFFFFFFF, 0xFFFFFFFF) -> 0, zero=1; AND/OR with 0xA5A5A5A5 and 0x0F0F0F0F -> 0x05050505 and 0xAFAFAFAF.
- Backpressure: hold out_ready=0 for 10 cycles while pulsing in_valid with new operands -> outputs unchanged, in_ready=0, new op not taken. Then out_ready=1 -> IDLE next cycle.
- Assert rst at bit_idx 10 of a SUB -> next cycle in_ready=1, out_valid=0. A following ADD 1 + 1 -> result 2, showing no stale carry.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl_pkg
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
// Contents:
//   - slice operation codes (ctrl[1:0])
//   - named 4-bit ctrl encodings (A_invert, B_invert, operation)
//   - compare-select encodings (bonus_op)
//   - sequencer FSM state constants
//   - compare_select(): maps less/equal onto the selected predicate
// -----------------------------------------------------------------------------
package alu_serial_ctrl_pkg;

  // Slice operation field, ctrl[1:0]
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  // Full ctrl encodings: {A_invert, B_invert, operation}
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;  // B inverted, carry-in 1
  localparam logic [3:0] CTRL_NOR  = 4'b1100;  // ~A & ~B
  localparam logic [3:0] CTRL_NAND = 4'b1101;  // ~A | ~B
  localparam logic [3:0] CTRL_CMP  = 4'b0111;  // subtract, then resolve

  // Compare select
  typedef enum logic [2:0] {
    BONUS_LT = 3'd0,
    BONUS_GT = 3'd1,
    BONUS_LE = 3'd2,
    BONUS_GE = 3'd3,
    BONUS_EQ = 3'd4,
    BONUS_NE = 3'd5,
    BONUS_Z6 = 3'd6,
    BONUS_Z7 = 3'd7
  } bonus_op_e;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic logic compare_select(input logic [2:0] bonus_op,
                                          input logic       less,
                                          input logic       equal);
    logic sel;
    sel = 1'b0;
    case (bonus_op_e'(bonus_op))
      BONUS_LT: sel = less;
      BONUS_GT: sel = ~less & ~equal;
      BONUS_LE: sel = less | equal;
      BONUS_GE: sel = ~less;
      BONUS_EQ: sel = equal;
      BONUS_NE: sel = ~equal;
      default:  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_bot.sv
// -----------------------------------------------------------------------------
// alu_bot
// Combinational 1-bit ALU slice.
// Ports:
//   a, b            operand bits
//   a_invert        invert a before use
//   b_invert        invert b before use
//   carry_in        carry into this bit
//   less, equal     compare flags, used only by operation 3
//   operation       0 AND, 1 OR, 2 sum, 3 compare-select
//   bonus_op        compare predicate select for operation 3
//   result          selected output bit
//   carry_out       full-adder carry out
//   overflow        carry_in ^ carry_out; signed overflow when this is the MSB
// -----------------------------------------------------------------------------
module alu_bot
  import alu_serial_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       carry_in,
  input  logic       less,
  input  logic       equal,
  input  logic [1:0] operation,
  input  logic [2:0] bonus_op,
  output logic       result,
  output logic       carry_out,
  output logic       overflow
);

  logic a_eff;
  logic b_eff;
  logic sum;

  assign a_eff     = a ^ a_invert;
  assign b_eff     = b ^ b_invert;
  assign sum       = a_eff ^ b_eff ^ carry_in;
  assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);
  assign overflow  = carry_in ^ carry_out;

  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      default: result = compare_select(bonus_op, less, equal);
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_serial_ctrl
// Bit-serial ALU sequencer. Accepts one WIDTH-bit operation and evaluates it
// LSB first through a single alu_bot slice, one bit per cycle. Compare ops
// take one extra cycle in which the slice resolves the predicate.
// Ports:
//   clk, rst            clock / synchronous active-high reset
//   in_valid, in_ready  request handshake (in_ready high only when idle)
//   ctrl                [3]=A_invert, [2]=B_invert, [1:0]=operation
//   bonus_op            compare predicate select
//   src1, src2          operands A and B
//   out_valid,out_ready result handshake
//   result, zero        result and result==0
//   cout, overflow      MSB carry / signed overflow, operation 2 only
// -----------------------------------------------------------------------------
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [2:0]       bonus_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [3:0]       ctrl_reg;
  logic [2:0]       bonus_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] bit_idx_reg;
  logic             diff_zero_reg;
  logic             msb_sum_reg;
  logic             msb_ovf_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             cout_reg;
  logic             overflow_reg;

  logic             slice_result;
  logic             slice_cout;
  logic             slice_ovf;
  logic [1:0]       slice_op;
  logic [WIDTH-1:0] res_next;

  // COMPARE runs the data bits as a plain sum; the predicate is only
  // selected in the RESOLVE cycle.
  always_comb begin
    slice_op = ctrl_reg[1:0];
    if (state_reg == ST_RESOLVE)
      slice_op = OP_CMP;
    else if (ctrl_reg[1:0] == OP_CMP)
      slice_op = OP_ADD;
  end

  assign res_next = {slice_result, res_sh_reg[WIDTH-1:1]};

  alu_bot u_slice (
    .a         (a_sh_reg[0]),
    .b         (b_sh_reg[0]),
    .a_invert  (ctrl_reg[3]),
    .b_invert  (ctrl_reg[2]),
    .carry_in  (carry_reg),
    .less      (msb_sum_reg ^ msb_ovf_reg),  // sign corrected for overflow
    .equal     (diff_zero_reg),
    .operation (slice_op),
    .bonus_op  (bonus_reg),
    .result    (slice_result),
    .carry_out (slice_cout),
    .overflow  (slice_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ctrl_reg      <= '0;
      bonus_reg     <= '0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_sh_reg    <= '0;
      carry_reg     <= 1'b0;
      bit_idx_reg   <= '0;
      diff_zero_reg <= 1'b1;
      msb_sum_reg   <= 1'b0;
      msb_ovf_reg   <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b1;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            ctrl_reg      <= ctrl;
            bonus_reg     <= bonus_op;
            a_sh_reg      <= src1;
            b_sh_reg      <= src2;
            carry_reg     <= ctrl[2];  // +1 of two's-complement negate
            bit_idx_reg   <= '0;
            diff_zero_reg <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sh_reg    <= res_next;
          a_sh_reg      <= a_sh_reg >> 1;
          b_sh_reg      <= b_sh_reg >> 1;
          carry_reg     <= slice_cout;
          diff_zero_reg <= diff_zero_reg & ~slice_result;
          bit_idx_reg   <= bit_idx_reg + CNT_W'(1);
          if (bit_idx_reg == LAST_IDX) begin
            msb_sum_reg <= slice_result;
            msb_ovf_reg <= slice_ovf;
            if (ctrl_reg[1:0] == OP_CMP) begin
              state_reg <= ST_RESOLVE;
            end else begin
              result_reg   <= res_next;
              zero_reg     <= (res_next == '0);
              cout_reg     <= (ctrl_reg[1:0] == OP_ADD) ? slice_cout : 1'b0;
              overflow_reg <= (ctrl_reg[1:0] == OP_ADD) ? slice_ovf : 1'b0;
              state_reg    <= ST_DONE;
            end
          end
        end
        ST_RESOLVE: begin
          result_reg   <= {{(WIDTH-1){1'b0}}, slice_result};
          zero_reg     <= ~slice_result;
          cout_reg     <= 1'b0;
          overflow_reg <= 1'b0;
          state_reg    <= ST_DONE;
        end
        default: begin  // ST_DONE: outputs held until consumed
          if (out_ready)
            state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign cout      = cout_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_ctrl
// Directed and random checks of alu_serial_ctrl against an arithmetic
// reference model of the operation set.
// -----------------------------------------------------------------------------
module tb_alu_serial_ctrl;
  import alu_serial_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [2:0]   bonus_op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .bonus_op  (bonus_op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate the op on whole words with ordinary arithmetic.
  function automatic void model(input logic [3:0] c, input logic [2:0] bo,
                                input logic [W-1:0] s1, input logic [W-1:0] s2,
                                output logic [W-1:0] r, output logic z,
                                output logic co, output logic ov);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
    longint       sv;
    bit           less;
    bit           eq;
    bit           sel;
    a  = c[3] ? ~s1 : s1;
    b  = c[2] ? ~s2 : s2;
    s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c[2]};
    sv = longint'($signed(a)) + longint'($signed(b)) + (c[2] ? 64'sd1 : 64'sd0);
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (c[1:0])
      2'd0: r = a & b;
      2'd1: r = a | b;
      2'd2: begin
        r  = s[W-1:0];
        co = s[W];
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      default: begin
        less = (sv < 0);
        eq   = (s[W-1:0] == '0);
        case (bo)
          3'd0: sel = less;
          3'd1: sel = !less && !eq;
          3'd2: sel = less || eq;
          3'd3: sel = !less;
          3'd4: sel = eq;
          3'd5: sel = !eq;
          default: sel = 1'b0;
        endcase
        r = {{(W-1){1'b0}}, sel};
      end
    endcase
    z = (r == '0);
  endfunction

  // Issue one op from IDLE, wait for out_valid (bounded), check all outputs
  // and the latency, then consume the result unless hold is set.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [2:0] bo,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic eco,
                       input logic eov, input int elat, input bit hold);
    int lat;
    ctrl = c; bonus_op = bo; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".result"}, 64'(result), 64'(er));
    check({tag, ".zero"}, 64'(zero), 64'(ez));
    check({tag, ".cout"}, 64'(cout), 64'(eco));
    check({tag, ".ovf"}, 64'(overflow), 64'(eov));
    $display("op %s ctrl=%b bonus=%0d a=%h b=%h -> result=%h z=%b c=%b v=%b lat=%0d",
             tag, c, bo, a, b, result, zero, cout, overflow, lat);
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic do_model_op(input string tag, input logic [3:0] c, input logic [2:0] bo,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic z, co, ov;
    model(c, bo, a, b, r, z, co, ov);
    do_op(tag, c, bo, a, b, r, z, co, ov, (c[1:0] == 2'd3) ? W + 1 : W, 1'b0);
  endtask

  initial begin
    logic [W-1:0] held_r;
    logic [3:0]   rc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ctrl = '0; bonus_op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.cout", 64'(cout), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op("add_ovf", CTRL_ADD, 3'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 32, 0);
    do_op("sub_5_5", CTRL_SUB, 3'd0, 32'd5, 32'd5, 32'h0, 1, 1, 0, 32, 0);
    do_op("sub_3_5", CTRL_SUB, 3'd0, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0, 0, 32, 0);
    do_op("lt", CTRL_CMP, 3'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 33, 0);
    do_op("gt", CTRL_CMP, 3'd1, 32'h80000000, 32'h1, 32'h0, 1, 0, 0, 33, 0);
    do_op("eq", CTRL_CMP, 3'd4, 32'd7, 32'd7, 32'h1, 0, 0, 0, 33, 0);
    do_op("ne", CTRL_CMP, 3'd5, 32'd7, 32'd7, 32'h0, 1, 0, 0, 33, 0);
    do_op("bonus6", CTRL_CMP, 3'd6, 32'd7, 32'd7, 32'h0, 1, 0, 0, 33, 0);
    do_op("nor", CTRL_NOR, 3'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 32, 0);
    do_op("nand", CTRL_NAND, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 32, 0);
    do_op("and", CTRL_AND, 3'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 0, 0, 0, 32, 0);
    do_op("or", CTRL_OR, 3'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF, 0, 0, 0, 32, 0);

    // Backpressure: result held, new requests refused
    do_op("bp", CTRL_ADD, 3'd0, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 32, 1);
    held_r = result;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; ctrl = CTRL_OR; src1 = $urandom; src2 = $urandom;
      @(posedge clk); #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.result", 64'(result), 64'h23456789);
      $display("bp cycle %0d in_ready=%b out_valid=%b result=%h", i, in_ready, out_valid, result);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release.in_ready", 64'(in_ready), 64'd1);
    check("bp.release.out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("bp.not_taken", 64'(in_ready), 64'd1);
    check("bp.held", 64'(result), 64'(held_r));

    // Reset in the middle of a SUB at bit 10
    ctrl = CTRL_SUB; bonus_op = 3'd0; src1 = 32'd100; src2 = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    $display("midrst in_ready=%b out_valid=%b", in_ready, out_valid);
    do_op("add_1_1", CTRL_ADD, 3'd0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 32, 0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_model_op("rand", rc, 3'($urandom), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
